// File: rtl/md5_pkg.sv
// Shared types and constants for the MD5 round sequencer: FSM states, round-function
// select, per-round rotate table and the message-word index schedule.
package md5_pkg;

   localparam int         NUM_STEPS = 64;
   localparam logic [5:0] LAST_STEP = 6'(NUM_STEPS - 1);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_INIT  = 3'd1,
      ST_ROUND = 3'd2,
      ST_FINAL = 3'd3,
      ST_DONE  = 3'd4
   } state_t;

   typedef enum logic [1:0] {
      FUNC_F = 2'd0,
      FUNC_G = 2'd1,
      FUNC_H = 2'd2,
      FUNC_I = 2'd3
   } func_t;

   typedef logic [4:0] shift_t;

   // Rotate amounts indexed [round][step within group of four].
   localparam shift_t [0:3][0:3] SHIFT_TBL = '{
      '{5'd7, 5'd12, 5'd17, 5'd22},
      '{5'd5, 5'd9,  5'd14, 5'd20},
      '{5'd4, 5'd11, 5'd16, 5'd23},
      '{5'd6, 5'd10, 5'd15, 5'd21}
   };

   // Only the low four bits of the step index matter since the result wraps mod 16.
   function automatic logic [3:0] msg_index(input logic [1:0] r, input logic [3:0] i_lo);
      logic [3:0] g;
      case (r)
         2'd0:    g = i_lo;
         2'd1:    g = i_lo * 4'd5 + 4'd1;
         2'd2:    g = i_lo * 4'd3 + 4'd5;
         default: g = i_lo * 4'd7;
      endcase
      return g;
   endfunction

endpackage

// File: rtl/md5_round_ctrl_if.sv
// Handshake and step-control bundle between the hash top-level / datapath (master)
// and the round sequencer (slave).
interface md5_round_ctrl_if;

   logic       start;
   logic       step_en;
   logic       busy;
   logic       init;
   logic       step_valid;
   logic [5:0] k_addr;
   logic [3:0] g_idx;
   logic [4:0] shift;
   logic [1:0] func_sel;
   logic       final_add;
   logic       done;

   modport master (
      output start, step_en,
      input  busy, init, step_valid, k_addr, g_idx, shift, func_sel, final_add, done
   );

   modport slave (
      input  start, step_en,
      output busy, init, step_valid, k_addr, g_idx, shift, func_sel, final_add, done
   );

endinterface

// File: rtl/md5_step_decode.sv
// Combinational per-step decode: step index -> message word index, rotate amount
// and round function.
module md5_step_decode
   import md5_pkg::*;
(
   input  logic [5:0] step,
   output logic [3:0] g_idx,
   output shift_t     shift,
   output func_t      func_sel
);

   logic [1:0] round;
   logic [1:0] lane;

   assign round = step[5:4];
   assign lane  = step[1:0];

   always_comb begin
      g_idx    = msg_index(round, step[3:0]);
      shift    = SHIFT_TBL[round][lane];
      func_sel = func_t'(round);
   end

endmodule

// File: rtl/md5_round_ctrl.sv
// Round sequencer for one MD5 block: chaining load, 64 stallable steps, final add, done.
//
//  state    | meaning
//  ---------+-------------------------------------------------------------
//  ST_IDLE  | waiting for start
//  ST_INIT  | init strobe, A..D loaded from chaining registers, i cleared
//  ST_ROUND | step i presented; retires on step_en, stalls otherwise
//  ST_FINAL | final_add strobe, chaining += A..D
//  ST_DONE  | done strobe, start ignored this cycle
module md5_round_ctrl
   import md5_pkg::*;
(
   input logic           clk,
   input logic           rst,
   md5_round_ctrl_if.slave bus
);

   state_t     state_q;
   state_t     state_d;
   logic [5:0] step_q;
   logic [5:0] step_d;
   logic [3:0] g_idx;
   shift_t     shift;
   func_t      func_sel;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         step_q  <= '0;
      end else begin
         state_q <= state_d;
         step_q  <= step_d;
      end
   end

   // Step index moves only on a retire, so the decoded outputs hold through stalls.
   always_comb begin
      state_d = state_q;
      step_d  = step_q;
      case (state_q)
         ST_IDLE: begin
            if (bus.start) state_d = ST_INIT;
         end
         ST_INIT: begin
            step_d  = '0;
            state_d = ST_ROUND;
         end
         ST_ROUND: begin
            if (bus.step_en) begin
               if (step_q == LAST_STEP) begin
                  step_d  = '0;
                  state_d = ST_FINAL;
               end else begin
                  step_d = step_q + 6'd1;
               end
            end
         end
         ST_FINAL: state_d = ST_DONE;
         ST_DONE:  state_d = ST_IDLE;
         default: begin
            state_d = ST_IDLE;
            step_d  = '0;
         end
      endcase
   end

   md5_step_decode u_decode (
      .step     (step_q),
      .g_idx    (g_idx),
      .shift    (shift),
      .func_sel (func_sel)
   );

   assign bus.busy       = (state_q != ST_IDLE);
   assign bus.init       = (state_q == ST_INIT);
   assign bus.step_valid = (state_q == ST_ROUND);
   assign bus.final_add  = (state_q == ST_FINAL);
   assign bus.done       = (state_q == ST_DONE);
   assign bus.k_addr     = step_q;
   assign bus.g_idx      = g_idx;
   assign bus.shift      = shift;
   assign bus.func_sel   = func_sel;

endmodule

// File: tb/tb_md5_round_ctrl.sv
// Directed bench for md5_round_ctrl: inputs driven and outputs sampled on the falling edge.
module tb_md5_round_ctrl;

   logic clk;
   logic rst;
   int   n_cmp;
   int   n_err;
   int   cyc;

   md5_round_ctrl_if bus ();

   md5_round_ctrl dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int sh_tbl [4][4] = '{'{7, 12, 17, 22}, '{5, 9, 14, 20}, '{4, 11, 16, 23}, '{6, 10, 15, 21}};

   function automatic int exp_g(input int i);
      int r;
      r = i / 16;
      case (r)
         0:       return i % 16;
         1:       return (5 * i + 1) % 16;
         2:       return (3 * i + 5) % 16;
         default: return (7 * i) % 16;
      endcase
   endfunction

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
      cyc++;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus.start = 1'b0;
      bus.step_en = 1'b0;
      repeat (2) @(negedge clk);
      n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
      n_cmp++; if (bus.init !== 1'b0) begin n_err++; $display("FAIL reset_init: got %b expected 0", bus.init); end
      n_cmp++; if (bus.step_valid !== 1'b0) begin n_err++; $display("FAIL reset_step_valid: got %b expected 0", bus.step_valid); end
      n_cmp++; if (bus.final_add !== 1'b0) begin n_err++; $display("FAIL reset_final_add: got %b expected 0", bus.final_add); end
      n_cmp++; if (bus.done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b expected 0", bus.done); end
      n_cmp++; if (bus.k_addr !== 6'd0) begin n_err++; $display("FAIL reset_k_addr: got %0d expected 0", bus.k_addr); end
      n_cmp++; if (bus.g_idx !== 4'd0) begin n_err++; $display("FAIL reset_g_idx: got %0d expected 0", bus.g_idx); end
      n_cmp++; if (bus.shift !== 5'd7) begin n_err++; $display("FAIL reset_shift: got %0d expected 7", bus.shift); end
      n_cmp++; if (bus.func_sel !== 2'd0) begin n_err++; $display("FAIL reset_func_sel: got %0d expected 0", bus.func_sel); end
      rst = 1'b0;
      tick();
   endtask

   task automatic test_full_run();
      logic [5:0] ek;
      logic [3:0] eg;
      logic [4:0] es;
      logic [1:0] ef;
      bus.step_en = 1'b1;
      bus.start = 1'b1;
      cyc = 0;
      tick();
      bus.start = 1'b0;
      n_cmp++; if (bus.init !== 1'b1 || bus.busy !== 1'b1 || bus.step_valid !== 1'b0) begin
         n_err++; $display("FAIL full_cycle1: got init=%b busy=%b sv=%b expected 1 1 0", bus.init, bus.busy, bus.step_valid);
      end
      for (int s = 0; s < 64; s++) begin
         tick();
         ek = 6'(s);
         eg = 4'(exp_g(s));
         es = 5'(sh_tbl[s / 16][s % 4]);
         ef = 2'(s / 16);
         n_cmp++; if (bus.step_valid !== 1'b1 || bus.init !== 1'b0 || bus.k_addr !== ek) begin
            n_err++; $display("FAIL full_step cyc %0d: got sv=%b init=%b k=%0d expected 1 0 %0d", cyc, bus.step_valid, bus.init, bus.k_addr, ek);
         end
         n_cmp++; if (bus.g_idx !== eg || bus.shift !== es || bus.func_sel !== ef) begin
            n_err++; $display("FAIL full_decode i=%0d: got g=%0d sh=%0d f=%0d expected %0d %0d %0d", s, bus.g_idx, bus.shift, bus.func_sel, eg, es, ef);
         end
         if (s == 17) begin
            n_cmp++; if (bus.g_idx !== 4'd6 || bus.shift !== 5'd9 || bus.func_sel !== 2'd1) begin
               n_err++; $display("FAIL spot_i17: got g=%0d sh=%0d f=%0d expected 6 9 1", bus.g_idx, bus.shift, bus.func_sel);
            end
         end
         if (s == 33) begin
            n_cmp++; if (bus.g_idx !== 4'd8 || bus.shift !== 5'd11 || bus.func_sel !== 2'd2) begin
               n_err++; $display("FAIL spot_i33: got g=%0d sh=%0d f=%0d expected 8 11 2", bus.g_idx, bus.shift, bus.func_sel);
            end
         end
         if (s == 63) begin
            n_cmp++; if (bus.g_idx !== 4'd9 || bus.shift !== 5'd21 || bus.func_sel !== 2'd3) begin
               n_err++; $display("FAIL spot_i63: got g=%0d sh=%0d f=%0d expected 9 21 3", bus.g_idx, bus.shift, bus.func_sel);
            end
         end
      end
      tick();
      n_cmp++; if (bus.final_add !== 1'b1 || bus.step_valid !== 1'b0 || bus.k_addr !== 6'd0) begin
         n_err++; $display("FAIL full_final cyc %0d: got fa=%b sv=%b k=%0d expected 1 0 0", cyc, bus.final_add, bus.step_valid, bus.k_addr);
      end
      tick();
      n_cmp++; if (bus.done !== 1'b1 || bus.busy !== 1'b1 || bus.final_add !== 1'b0) begin
         n_err++; $display("FAIL full_done cyc %0d: got done=%b busy=%b fa=%b expected 1 1 0", cyc, bus.done, bus.busy, bus.final_add);
      end
      tick();
      n_cmp++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
         n_err++; $display("FAIL full_idle cyc %0d: got busy=%b done=%b expected 0 0", cyc, bus.busy, bus.done);
      end
   endtask

   task automatic test_stall();
      logic pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
      int   exp_i;
      int   stalls;
      int   pc;
      bit   seen_done;
      logic en;
      exp_i = 0; stalls = 0; pc = 0; seen_done = 0;
      bus.step_en = 1'b0;
      bus.start = 1'b1;
      cyc = 0;
      tick();
      bus.start = 1'b0;
      while (!seen_done && cyc < 400) begin
         if (bus.step_valid) begin
            n_cmp++; if (bus.k_addr !== 6'(exp_i) || bus.g_idx !== 4'(exp_g(exp_i)) || bus.shift !== 5'(sh_tbl[exp_i / 16][exp_i % 4])) begin
               n_err++; $display("FAIL stall_step cyc %0d: got k=%0d g=%0d sh=%0d expected k=%0d", cyc, bus.k_addr, bus.g_idx, bus.shift, exp_i);
            end
            en = pat[pc % 4];
            pc++;
            if (en) exp_i++; else stalls++;
            bus.step_en = en;
         end else begin
            bus.step_en = 1'b0;
            if (bus.done) seen_done = 1;
         end
         if (!seen_done) tick();
      end
      n_cmp++; if (!seen_done || cyc != 67 + stalls || exp_i != 64) begin
         n_err++; $display("FAIL stall_done: got seen=%0d cyc=%0d retired=%0d expected 1 %0d 64", seen_done, cyc, exp_i, 67 + stalls);
      end
      bus.step_en = 1'b1;
      tick();
   endtask

   task automatic test_ignored_start();
      int n;
      bus.step_en = 1'b1;
      bus.start = 1'b1;
      cyc = 0;
      tick();
      bus.start = 1'b0;
      n = 0;
      while (!(bus.step_valid && bus.k_addr == 6'd20) && n < 100) begin tick(); n++; end
      n_cmp++; if (cyc != 22) begin n_err++; $display("FAIL ign_reach20: got cyc %0d expected 22", cyc); end
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      n_cmp++; if (bus.k_addr !== 6'd21 || bus.init !== 1'b0 || bus.step_valid !== 1'b1) begin
         n_err++; $display("FAIL ign_mid: got k=%0d init=%b sv=%b expected 21 0 1", bus.k_addr, bus.init, bus.step_valid);
      end
      n = 0;
      while (!bus.done && n < 100) begin tick(); n++; end
      n_cmp++; if (bus.done !== 1'b1 || cyc != 67) begin n_err++; $display("FAIL ign_done: got done=%b cyc=%0d expected 1 67", bus.done, cyc); end
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL ign_after_done: got busy=%b expected 0", bus.busy); end
      tick();
      n_cmp++; if (bus.busy !== 1'b0 || bus.init !== 1'b0) begin
         n_err++; $display("FAIL ign_stay_idle: got busy=%b init=%b expected 0 0", bus.busy, bus.init);
      end
   endtask

   task automatic test_back_to_back();
      int n;
      bus.step_en = 1'b1;
      bus.start = 1'b1;
      cyc = 0;
      tick();
      n_cmp++; if (bus.init !== 1'b1) begin n_err++; $display("FAIL b2b_init1: got %b expected 1", bus.init); end
      n = 0;
      while (!bus.done && n < 100) begin tick(); n++; end
      n_cmp++; if (bus.done !== 1'b1 || cyc != 67) begin n_err++; $display("FAIL b2b_done1: got done=%b cyc=%0d expected 1 67", bus.done, cyc); end
      tick();
      n_cmp++; if (bus.busy !== 1'b0 || bus.init !== 1'b0) begin
         n_err++; $display("FAIL b2b_gap: got busy=%b init=%b expected 0 0", bus.busy, bus.init);
      end
      tick();
      n_cmp++; if (bus.init !== 1'b1 || bus.busy !== 1'b1) begin
         n_err++; $display("FAIL b2b_init2: got init=%b busy=%b expected 1 1", bus.init, bus.busy);
      end
      bus.start = 1'b0;
      n = 0;
      while (!bus.done && n < 100) begin tick(); n++; end
      n_cmp++; if (bus.done !== 1'b1 || cyc != 135) begin n_err++; $display("FAIL b2b_done2: got done=%b cyc=%0d expected 1 135", bus.done, cyc); end
      tick();
   endtask

   task automatic test_async_reset();
      int  n;
      bit  stray;
      bus.step_en = 1'b1;
      bus.start = 1'b1;
      cyc = 0;
      tick();
      bus.start = 1'b0;
      n = 0;
      while (!(bus.step_valid && bus.k_addr == 6'd40) && n < 100) begin tick(); n++; end
      n_cmp++; if (cyc != 42) begin n_err++; $display("FAIL rst_reach40: got cyc %0d expected 42", cyc); end
      #2 rst = 1'b1;
      #1;
      n_cmp++; if (bus.busy !== 1'b0 || bus.step_valid !== 1'b0 || bus.init !== 1'b0 || bus.final_add !== 1'b0 || bus.done !== 1'b0) begin
         n_err++; $display("FAIL rst_async_ctrl: got busy=%b sv=%b init=%b fa=%b done=%b expected all 0", bus.busy, bus.step_valid, bus.init, bus.final_add, bus.done);
      end
      n_cmp++; if (bus.k_addr !== 6'd0 || bus.g_idx !== 4'd0 || bus.shift !== 5'd7 || bus.func_sel !== 2'd0) begin
         n_err++; $display("FAIL rst_async_step: got k=%0d g=%0d sh=%0d f=%0d expected 0 0 7 0", bus.k_addr, bus.g_idx, bus.shift, bus.func_sel);
      end
      stray = 0;
      repeat (3) begin
         tick();
         if (bus.final_add || bus.done || bus.busy) stray = 1;
      end
      rst = 1'b0;
      repeat (3) begin
         tick();
         if (bus.final_add || bus.done || bus.busy) stray = 1;
      end
      n_cmp++; if (stray) begin n_err++; $display("FAIL rst_no_finish: got stray strobe/busy=1 expected 0"); end
      bus.start = 1'b1;
      cyc = 0;
      tick();
      bus.start = 1'b0;
      n_cmp++; if (bus.init !== 1'b1 || bus.k_addr !== 6'd0) begin
         n_err++; $display("FAIL rst_restart_init: got init=%b k=%0d expected 1 0", bus.init, bus.k_addr);
      end
      n = 0;
      while (!bus.done && n < 100) begin tick(); n++; end
      n_cmp++; if (bus.done !== 1'b1 || cyc != 67) begin n_err++; $display("FAIL rst_restart_done: got done=%b cyc=%0d expected 1 67", bus.done, cyc); end
      tick();
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      cyc = 0;
      test_reset();
      test_full_run();
      test_stall();
      test_ignored_start();
      test_back_to_back();
      test_async_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
